// File: rtl/mips_pkg.sv
// Shared MIPS definitions: funct codes for the HI/LO unit and its FSM state type.
package mips_pkg;

  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  localparam int MD_STEPS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  function automatic logic [31:0] abs_if(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: 32 radix-2 steps on unsigned
// magnitudes, then one fix-up cycle that restores signs and commits the result.
module muldiv_unit
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e   r_state;
  logic [5:0]  r_cnt;
  logic        r_is_div;
  logic        r_neg_p;
  logic        r_neg_r;
  logic        r_div0;
  logic [31:0] r_opb;
  logic [63:0] r_acc;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;

  md_state_e   w_state_nx;
  logic [5:0]  w_cnt_nx;
  logic        w_is_div_nx;
  logic        w_neg_p_nx;
  logic        w_neg_r_nx;
  logic        w_div0_nx;
  logic [31:0] w_opb_nx;
  logic [63:0] w_acc_nx;
  logic [31:0] w_hi_nx;
  logic [31:0] w_lo_nx;
  logic        w_done_nx;

  logic        w_signed;
  logic        w_is_md;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_step;
  logic [63:0] w_mul_fix;
  logic [32:0] w_div_hi;
  logic        w_div_ge;
  logic [31:0] w_div_sub;
  logic [63:0] w_div_step;

  assign w_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  assign w_is_md  = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
                    (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);

  // Multiply: acc = {partial product, remaining multiplier}; the 33-bit sum keeps the carry.
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);
  assign w_mul_step = {w_mul_sum, r_acc[31:1]};
  assign w_mul_fix  = r_neg_p ? (~r_acc + 64'd1) : r_acc;

  // Divide: acc = {remainder, quotient}; restoring step on the left-shifted remainder.
  assign w_div_hi   = r_acc[63:31];
  assign w_div_ge   = w_div_hi >= {1'b0, r_opb};
  assign w_div_sub  = w_div_hi[31:0] - r_opb;
  assign w_div_step = {(w_div_ge ? w_div_sub : w_div_hi[31:0]), r_acc[30:0], w_div_ge};

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_is_div_nx = r_is_div;
    w_neg_p_nx  = r_neg_p;
    w_neg_r_nx  = r_neg_r;
    w_div0_nx   = r_div0;
    w_opb_nx    = r_opb;
    w_acc_nx    = r_acc;
    w_hi_nx     = r_hi;
    w_lo_nx     = r_lo;
    w_done_nx   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (funct == FUNCT_MTHI) begin
            w_hi_nx = a;
          end else if (funct == FUNCT_MTLO) begin
            w_lo_nx = a;
          end else if (w_is_md) begin
            w_state_nx  = ST_RUN;
            w_cnt_nx    = 6'd0;
            w_is_div_nx = funct[1];
            w_neg_p_nx  = w_signed & (a[31] ^ b[31]);
            w_neg_r_nx  = w_signed & a[31];
            w_div0_nx   = (b == 32'd0);
            w_opb_nx    = abs_if(b, w_signed);
            w_acc_nx    = {32'd0, abs_if(a, w_signed)};
          end
        end
      end
      ST_RUN: begin
        w_acc_nx = r_is_div ? w_div_step : w_mul_step;
        w_cnt_nx = r_cnt + 6'd1;
        if (r_cnt == 6'(MD_STEPS - 1)) begin
          w_state_nx = ST_FIX;
        end
      end
      ST_FIX: begin
        w_state_nx = ST_IDLE;
        w_done_nx  = 1'b1;
        if (r_is_div) begin
          // A zero divisor leaves remainder = |a|, so only the quotient needs forcing.
          w_lo_nx = r_div0 ? 32'hFFFF_FFFF : (r_neg_p ? (~r_acc[31:0] + 32'd1) : r_acc[31:0]);
          w_hi_nx = r_neg_r ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
        end else begin
          w_hi_nx = w_mul_fix[63:32];
          w_lo_nx = w_mul_fix[31:0];
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 6'd0;
      r_is_div <= 1'b0;
      r_neg_p  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_opb    <= 32'd0;
      r_acc    <= 64'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_is_div <= w_is_div_nx;
      r_neg_p  <= w_neg_p_nx;
      r_neg_r  <= w_neg_r_nx;
      r_div0   <= w_div0_nx;
      r_opb    <= w_opb_nx;
      r_acc    <= w_acc_nx;
      r_hi     <= w_hi_nx;
      r_lo     <= w_lo_nx;
      r_done   <= w_done_nx;
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  funct = 6'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad = 0;

  muldiv_unit dut (
    .clk(clk), .reset_n(reset_n), .start(start), .funct(funct),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: {hi, lo} straight from the architectural definition.
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = 64'd0;
    case (f)
      F_MULT:  r = 64'(sx * sy);
      F_MULTU: r = {32'd0, x} * {32'd0, y};
      F_DIV:   r = (y == 32'd0) ? {x, 32'hFFFF_FFFF} : {32'(sx % sy), 32'(sx / sy)};
      F_DIVU:  r = (y == 32'd0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rnd_operand();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0:       v = $urandom_range(0, 20);
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      3:       v = -($urandom_range(1, 20));
      4:       v = 32'd0;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Issues one op and waits (bounded) for done; reports latency and protocol observations.
  task automatic issue_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int busy_n, output int overlap, output int chg);
    logic [31:0] h0, l0;
    @(negedge clk);
    start = 1'b1; funct = f; a = x; b = y;
    h0 = hi; l0 = lo;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; overlap = 0; chg = 0;
    busy_n = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (busy === 1'b1) busy_n++;
      if (busy === 1'b1 && done === 1'b1) overlap++;
      if (done !== 1'b1 && (hi !== h0 || lo !== l0)) chg++;
    end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #2;
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL reset_flags: busy/done=%b required 00", {busy, done}); end
    total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL reset_hilo: got %h required 0", {hi, lo}); end
    @(posedge clk); @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk); start = 1'b1; funct = F_MTHI; a = 32'hDEAD_BEEF;
    @(posedge clk); #1; start = 1'b0;
    total++; if (hi !== 32'hDEAD_BEEF || lo !== 32'd0) begin bad++; $display("FAIL mthi: hi=%h lo=%h required DEADBEEF/0", hi, lo); end
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL mthi_flags: busy/done=%b required 00", {busy, done}); end
    $display("MTHI a=DEADBEEF -> hi=%h lo=%h", hi, lo);
    @(negedge clk); start = 1'b1; funct = F_MTLO; a = 32'h0BAD_F00D;
    @(posedge clk); #1; start = 1'b0;
    total++; if (hi !== 32'hDEAD_BEEF || lo !== 32'h0BAD_F00D) begin bad++; $display("FAIL mtlo: hi=%h lo=%h required DEADBEEF/0BADF00D", hi, lo); end
    @(posedge clk); #1;
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL mtlo_flags: busy/done=%b required 00", {busy, done}); end
    $display("MTLO a=0BADF00D -> hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_ignored_funct();
    @(negedge clk); start = 1'b1; funct = 6'b100000; a = 32'h1111_2222; b = 32'h3;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'hDEAD_BEEF || lo !== 32'h0BAD_F00D) begin
      bad++; $display("FAIL ignored_funct: busy=%b done=%b hi=%h lo=%h required 0 0 DEADBEEF 0BADF00D", busy, done, hi, lo);
    end
    $display("funct 100000 ignored: hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_directed();
    logic [5:0]  tf [7] = '{F_MULTU, F_MULT, F_DIVU, F_DIV, F_DIV, F_DIV, F_DIVU};
    logic [31:0] ta [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd7, 32'hFFFF_FFF9, 32'h8000_0000, 32'h1234_5678, 32'hCAFE_0001};
    logic [31:0] tb [7] = '{32'hFFFF_FFFF, 32'd3, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] th [7] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'h1234_5678, 32'hCAFE_0001};
    logic [31:0] tl [7] = '{32'd1, 32'hFFFF_FFFA, 32'd3, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    int lat, busy_n, overlap, chg;
    for (int i = 0; i < 7; i++) begin
      issue_op(tf[i], ta[i], tb[i], lat, busy_n, overlap, chg);
      total++; if (lat !== 33) begin bad++; $display("FAIL dir_latency[%0d]: got %0d required 33", i, lat); end
      total++; if (busy_n !== 33) begin bad++; $display("FAIL dir_busy_cycles[%0d]: got %0d required 33", i, busy_n); end
      total++; if (overlap !== 0 || chg !== 0) begin bad++; $display("FAIL dir_protocol[%0d]: overlap=%0d early_write=%0d required 0 0", i, overlap, chg); end
      total++; if (hi !== th[i] || lo !== tl[i]) begin bad++; $display("FAIL dir_result[%0d]: hi=%h lo=%h required %h %h", i, hi, lo, th[i], tl[i]); end
      $display("funct=%b a=%h b=%h -> hi=%h lo=%h lat=%0d", tf[i], ta[i], tb[i], hi, lo, lat);
      @(posedge clk); #1;
      total++; if (done !== 1'b0) begin bad++; $display("FAIL dir_done_width[%0d]: done=%b required 0", i, done); end
    end
  endtask

  task automatic test_random();
    logic [5:0]  ops [4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
    logic [5:0]  f;
    logic [31:0] x, y;
    logic [63:0] exp_r;
    int lat, busy_n, overlap, chg;
    for (int i = 0; i < 24; i++) begin
      f = ops[$urandom_range(0, 3)];
      x = rnd_operand();
      y = rnd_operand();
      exp_r = model(f, x, y);
      issue_op(f, x, y, lat, busy_n, overlap, chg);
      total++; if ({hi, lo} !== exp_r || lat !== 33 || overlap !== 0 || chg !== 0) begin
        bad++; $display("FAIL rand[%0d]: funct=%b a=%h b=%h got %h lat=%0d ov=%0d chg=%0d required %h lat=33", i, f, x, y, {hi, lo}, lat, overlap, chg, exp_r);
      end
      $display("rand funct=%b a=%h b=%h -> hi=%h lo=%h", f, x, y, hi, lo);
    end
  endtask

  task automatic test_busy_ignore();
    int k;
    @(negedge clk); start = 1'b1; funct = F_DIVU; a = 32'd100; b = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    k = 0;
    repeat (4) begin @(posedge clk); #1; k++; end
    @(negedge clk); start = 1'b1; funct = F_MTLO; a = 32'hAAAA_5555;
    @(posedge clk); #1; k++;
    @(negedge clk); funct = F_MTHI; a = 32'h5555_AAAA;
    @(posedge clk); #1; k++;
    @(negedge clk); funct = F_MULT; a = 32'd9; b = 32'd9;
    @(posedge clk); #1; k++; start = 1'b0;
    while (done !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
    total++; if (k !== 33) begin bad++; $display("FAIL busy_ignore_latency: got %0d required 33", k); end
    total++; if (hi !== 32'd2 || lo !== 32'd14) begin bad++; $display("FAIL busy_ignore_result: hi=%h lo=%h required 2 E", hi, lo); end
    $display("DIVU 100/7 with MTLO/MTHI/MULT while busy -> hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_reset_abort();
    int ev, lat;
    @(negedge clk); start = 1'b1; funct = F_DIVU; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      bad++; $display("FAIL async_abort: busy=%b done=%b hi=%h lo=%h required 0 0 0 0", busy, done, hi, lo);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    ev = 0;
    repeat (40) begin @(posedge clk); #1; if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) ev++; end
    total++; if (ev !== 0) begin bad++; $display("FAIL abort_quiet: %0d cycles with activity required 0", ev); end
    $display("DIVU aborted by reset at cycle 10: hi=%h lo=%h", hi, lo);
    // Start presented together with reset release must be taken on the very next edge.
    @(negedge clk) reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk); reset_n = 1'b1; start = 1'b1; funct = F_MULTU; a = 32'h0001_0000; b = 32'h0003_0005;
    @(posedge clk); #1; start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL first_edge_accept: busy=%b required 1", busy); end
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    total++; if (lat !== 33 || hi !== 32'h0000_0003 || lo !== 32'h0005_0000) begin
      bad++; $display("FAIL post_reset_multu: lat=%0d hi=%h lo=%h required 33 00000003 00050000", lat, hi, lo);
    end
    $display("MULTU after reset -> hi=%h lo=%h lat=%0d", hi, lo, lat);
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_ignored_funct();
    test_directed();
    test_random();
    test_busy_ignore();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL provide: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL provide: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide: start  input  1  issue strobe, sampled on the rising edge.
REQ-004 SHALL provide: funct  input  6  MIPS funct code of the issued instruction.
REQ-005 SHALL provide: a  input  32  rs operand, the dividend or multiplicand.
REQ-006 SHALL provide: b  input  32  rt operand, the divisor or multiplier.
REQ-007 SHALL provide: busy  output  1  high while a MULT/DIV operation is in flight.
REQ-008 SHALL provide: done  output  1  one-cycle pulse when hi/lo receive a MULT/DIV result.
REQ-009 SHALL provide: hi, lo  output  32 each  architectural HI/LO registers.

Function
REQ-010 Accepted funct codes SHALL be MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MTHI 010001 and MTLO 010011; start with any other funct SHALL be ignored.
REQ-011 FSM states SHALL be IDLE, RUN and FIX; only IDLE SHALL accept start.
REQ-012 start with MTHI/MTLO in IDLE: hi (or lo) SHALL load a at that edge; busy and done stay low; the other register is unchanged.
REQ-013 start with MULT*/DIV* in IDLE: at the accepting edge E0, latch operands (magnitudes for signed ops, plus sign flags), clear the 6-bit counter, go to RUN; busy high from E0.
REQ-014 RUN SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per cycle on edges E1..E32, then go to FIX.
REQ-015 FIX (edge E33) SHALL apply sign correction and write hi/lo, clear busy, and return to IDLE; done SHALL be high for exactly the cycle following E33.
REQ-016 Latency SHALL be a constant 33 cycles for all four ops, signed or unsigned.
REQ-017 Multiply: {hi,lo} SHALL equal the 64-bit product (two's complement for MULT).
REQ-018 Divide: lo SHALL be the quotient truncated toward zero; hi SHALL be the remainder with the sign of the dividend.
REQ-019 Divisor zero SHALL give lo = FFFFFFFF and hi = a, for DIV and DIVU.
REQ-020 DIV 80000000 / FFFFFFFF SHALL give lo = 80000000 and hi = 00000000.
REQ-021 hi/lo SHALL hold their previous values throughout RUN; partial results stay in internal registers.
REQ-022 start while busy SHALL be ignored, including MTHI/MTLO; the requester stalls on busy.
REQ-023 done and busy SHALL never be high in the same cycle.

Reset
REQ-024 reset_n low SHALL immediately, without waiting for a clock edge, force the FSM to IDLE and set busy = 0, done = 0, hi = 0, lo = 0, counter = 0.
REQ-025 Reset during RUN or FIX SHALL abort the operation with no later write or done pulse.
REQ-026 The first start SHALL be accepted on the first rising edge after reset_n deasserts.

Structure
REQ-027 funct constants and the FSM state enum SHALL live in the shared mips_pkg package.
REQ-028 No sub-module is required; the 64-bit iterative datapath and FSM SHALL be inline in muldiv_unit.
REQ-029 The block SHALL use one sequential process with asynchronous reset and one combinational next-state/step process.

Verification
REQ-030 MULTU a=FFFFFFFF b=FFFFFFFF -> after 33 cycles hi=FFFFFFFE lo=00000001, done for 1 cycle, busy high for cycles 1-33.
REQ-031 MULT a=FFFFFFFE b=00000003 -> hi=FFFFFFFF lo=FFFFFFFA; DIVU a=7 b=2 -> lo=00000003 hi=00000001.
REQ-032 DIV a=FFFFFFF9 b=00000002 -> lo=FFFFFFFD hi=FFFFFFFF; DIV a=80000000 b=FFFFFFFF -> lo=80000000 hi=00000000.
REQ-033 DIV a=12345678 b=0 -> lo=FFFFFFFF hi=12345678 at cycle 33.
REQ-034 MTHI a=DEADBEEF in IDLE -> hi=DEADBEEF after 1 edge, busy/done stay 0, lo unchanged; MTLO issued during a DIVU -> ignored, lo takes only the DIVU result.
REQ-035 reset_n low at cycle 10 of DIVU -> busy=0, hi=lo=0 asynchronously, no done pulse afterwards; a new MULTU issued after release completes normally.
